// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg -- shared types, constants and helpers for the serial
// add/subtract engine.
//   addsub_state_t : controller states (IDLE, RUN, DONE)
//   MODE_SUB/ADD   : encoding of the mode input
//   signed_ovf()   : two's-complement overflow from the three sign bits
package serial_addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } addsub_state_t;

   localparam logic MODE_SUB = 1'b0;
   localparam logic MODE_ADD = 1'b1;

   // Overflow is decided purely from operand and result sign bits: an add
   // overflows when like-signed operands give a result of the other sign, a
   // subtract when unlike-signed operands give a result whose sign differs
   // from the minuend.
   function automatic logic signed_ovf(input logic mode,
                                       input logic a_msb,
                                       input logic b_msb,
                                       input logic r_msb);
      logic same_sign;
      logic flipped;
      same_sign = (a_msb == b_msb);
      flipped   = (r_msb != a_msb);
      if (mode == MODE_ADD) begin
         return same_sign && flipped;
      end else begin
         return !same_sign && flipped;
      end
   endfunction

endpackage

// File: rtl/serial_addsub_bit.sv
// addsub_bit -- one-bit full add/subtract cell.
//   x, y : operand bits (minuend/subtrahend or addends)
//   ci   : incoming borrow (sub) or carry (add)
//   mode : MODE_SUB or MODE_ADD
//   s    : difference/sum bit
//   co   : outgoing borrow (sub) or carry (add)
module addsub_bit
   import serial_addsub_pkg::*;
(
   input  logic x,
   input  logic y,
   input  logic ci,
   input  logic mode,
   output logic s,
   output logic co
);

   // Sum bit is shared by both modes; only the carry/borrow term differs.
   always_comb begin
      s = x ^ y ^ ci;
      if (mode == MODE_ADD) begin
         co = (x & y) | ((x ^ y) & ci);
      end else begin
         co = (~x & y) | (~(x ^ y) & ci);
      end
   end

endmodule

// File: rtl/serial_addsub.sv
// serial_addsub -- multi-cycle WIDTH-bit add/subtract, STEP bits per clock,
// LSB chunk first, with a registered borrow/carry between chunks.
//   clk, rst      : clock, asynchronous active-high reset
//   start         : request, sampled only in IDLE
//   mode          : 0 = a - b - cin, 1 = a + b + cin
//   a, b, cin     : operands, captured with start
//   busy          : high while chunks are being processed
//   done          : one-cycle completion pulse
//   result        : final difference/sum, held until the next completion
//   cout          : final borrow (sub) or carry (add)
//   ovf           : two's-complement signed overflow
module serial_addsub
   import serial_addsub_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int STEP  = 1
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf
);

   localparam int N  = WIDTH / STEP;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   generate
      if (WIDTH < 1 || STEP < 1 || (WIDTH % STEP) != 0) begin : g_bad_params
         $error("serial_addsub: STEP must be >= 1 and divide WIDTH");
      end
   endgenerate

   addsub_state_t    state;
   addsub_state_t    state_next;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] r_sh;
   logic [WIDTH-1:0] r_next;
   logic [WIDTH-1:0] chunk_ext;
   logic             carry;
   logic             op_mode;
   logic             a_msb;
   logic             b_msb;
   logic [CW-1:0]    cnt;
   logic             last_chunk;
   logic [STEP:0]    chain;
   logic [STEP-1:0]  chunk;

   assign chain[0]   = carry;
   assign last_chunk = (cnt == CW'(N - 1));

   // STEP cells rippling through the low bits of the operand shift registers.
   generate
      for (genvar i = 0; i < STEP; i++) begin : g_cell
         addsub_bit u_cell (
            .x    (a_sh[i]),
            .y    (b_sh[i]),
            .ci   (chain[i]),
            .mode (op_mode),
            .s    (chunk[i]),
            .co   (chain[i+1])
         );
      end
   endgenerate

   // New chunk enters the working register from the top, so after N chunks
   // the first one has migrated down to bit 0.
   always_comb begin
      chunk_ext                  = {WIDTH{1'b0}};
      chunk_ext[WIDTH-1 -: STEP] = chunk;
      r_next                     = (r_sh >> STEP) | chunk_ext;
   end

   // Next-state logic for the IDLE -> RUN -> DONE -> IDLE sequence.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = RUN;
            end else begin
               state_next = IDLE;
            end
         end
         RUN: begin
            if (last_chunk) begin
               state_next = DONE;
            end else begin
               state_next = RUN;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // busy/done are registered copies of the state being entered, so they
   // line up with the state without any combinational path to the outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= (state_next == RUN);
         done <= (state_next == DONE);
      end
   end

   // Operand capture, per-chunk datapath, and result registers that are only
   // written on the final chunk so partial values never reach the outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh    <= {WIDTH{1'b0}};
         b_sh    <= {WIDTH{1'b0}};
         r_sh    <= {WIDTH{1'b0}};
         carry   <= 1'b0;
         op_mode <= 1'b0;
         a_msb   <= 1'b0;
         b_msb   <= 1'b0;
         cnt     <= {CW{1'b0}};
         result  <= {WIDTH{1'b0}};
         cout    <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh    <= a;
                  b_sh    <= b;
                  r_sh    <= {WIDTH{1'b0}};
                  carry   <= cin;
                  op_mode <= mode;
                  a_msb   <= a[WIDTH-1];
                  b_msb   <= b[WIDTH-1];
                  cnt     <= {CW{1'b0}};
               end
            end
            RUN: begin
               a_sh  <= a_sh >> STEP;
               b_sh  <= b_sh >> STEP;
               r_sh  <= r_next;
               carry <= chain[STEP];
               cnt   <= cnt + CW'(1);
               if (last_chunk) begin
                  result <= r_next;
                  cout   <= chain[STEP];
                  ovf    <= signed_ovf(op_mode, a_msb, b_msb, r_next[WIDTH-1]);
               end
            end
            DONE: begin
               cnt <= {CW{1'b0}};
            end
            default: begin
               cnt <= {CW{1'b0}};
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       mode = 1'b0;
   logic       cin = 1'b0;
   logic [7:0] a = 8'h00;
   logic [7:0] b = 8'h00;
   int         sel = 0;   // 0: W8/S1, 1: W1/S1, 2: W8/S4

   logic       busy0, done0, cout0, ovf0;
   logic [7:0] res0;
   logic       busy1, done1, cout1, ovf1;
   logic [0:0] res1;
   logic       busy2, done2, cout2, ovf2;
   logic [7:0] res2;

   logic       o_busy, o_done, o_cout, o_ovf;
   logic [7:0] o_result;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   serial_addsub #(.WIDTH(8), .STEP(1)) u_w8s1 (
      .clk(clk), .rst(rst), .start(start && (sel == 0)), .mode(mode),
      .a(a), .b(b), .cin(cin), .busy(busy0), .done(done0),
      .result(res0), .cout(cout0), .ovf(ovf0));

   serial_addsub #(.WIDTH(1), .STEP(1)) u_w1s1 (
      .clk(clk), .rst(rst), .start(start && (sel == 1)), .mode(mode),
      .a(a[0:0]), .b(b[0:0]), .cin(cin), .busy(busy1), .done(done1),
      .result(res1), .cout(cout1), .ovf(ovf1));

   serial_addsub #(.WIDTH(8), .STEP(4)) u_w8s4 (
      .clk(clk), .rst(rst), .start(start && (sel == 2)), .mode(mode),
      .a(a), .b(b), .cin(cin), .busy(busy2), .done(done2),
      .result(res2), .cout(cout2), .ovf(ovf2));

   always_comb begin
      o_busy = 1'b0; o_done = 1'b0; o_cout = 1'b0; o_ovf = 1'b0; o_result = 8'h00;
      case (sel)
         0: begin o_busy = busy0; o_done = done0; o_cout = cout0; o_ovf = ovf0; o_result = res0; end
         1: begin o_busy = busy1; o_done = done1; o_cout = cout1; o_ovf = ovf1; o_result = {7'd0, res1}; end
         2: begin o_busy = busy2; o_done = done2; o_cout = cout2; o_ovf = ovf2; o_result = res2; end
         default: o_busy = 1'b0;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int cfg_width(input int s);
      return (s == 1) ? 1 : 8;
   endfunction

   function automatic int cfg_chunks(input int s);
      return (s == 0) ? 8 : ((s == 1) ? 1 : 2);
   endfunction

   // Reference: plain integer arithmetic on the operand values.
   function automatic void model(input int w, input logic m, input logic [7:0] av,
                                 input logic [7:0] bv, input logic c,
                                 output logic [7:0] r, output logic co, output logic ov);
      int  mask, ai, bi, ci, full;
      logic am, bm, rm;
      mask = (1 << w) - 1;
      ai   = int'(av) & mask;
      bi   = int'(bv) & mask;
      ci   = c ? 1 : 0;
      if (m) begin
         full = ai + bi + ci;
         co   = ((full >> w) & 1) != 0;
      end else begin
         full = ai - bi - ci;
         co   = (ai < bi + ci);
      end
      r  = 8'(full & mask);
      am = ((ai >> (w - 1)) & 1) != 0;
      bm = ((bi >> (w - 1)) & 1) != 0;
      rm = ((int'(r) >> (w - 1)) & 1) != 0;
      ov = m ? ((am == bm) && (rm != am)) : ((am != bm) && (rm != am));
   endfunction

   task automatic run_op(input string tag, input logic m, input logic [7:0] av,
                         input logic [7:0] bv, input logic c);
      logic [7:0] er;
      logic       ec, eo;
      int         n, cyc, busy_cnt;
      n = cfg_chunks(sel);
      model(cfg_width(sel), m, av, bv, c, er, ec, eo);
      @(negedge clk);
      mode = m; a = av; b = bv; cin = c; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); mode = 1'($urandom);
      check($sformatf("%s.busy_e0", tag), {31'd0, o_busy}, 32'd1);
      busy_cnt = o_busy ? 1 : 0;
      cyc = 0;
      while (o_done !== 1'b1 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (o_busy === 1'b1) busy_cnt++;
      end
      check($sformatf("%s.latency", tag), cyc, n);
      check($sformatf("%s.busy_cycles", tag), busy_cnt, n);
      check($sformatf("%s.busy_at_done", tag), {31'd0, o_busy}, 32'd0);
      check($sformatf("%s.result", tag), {24'd0, o_result}, {24'd0, er});
      check($sformatf("%s.cout", tag), {31'd0, o_cout}, {31'd0, ec});
      check($sformatf("%s.ovf", tag), {31'd0, o_ovf}, {31'd0, eo});
      @(posedge clk); #1;
      check($sformatf("%s.done_drop", tag), {31'd0, o_done}, 32'd0);
      check($sformatf("%s.result_hold", tag), {24'd0, o_result}, {24'd0, er});
   endtask

   initial begin
      logic [7:0] er, first_res;
      logic       ec, eo;
      int         dones, done_edge;

      // reset state of every instance
      #12;
      for (int s = 0; s < 3; s++) begin
         sel = s; #1;
         check($sformatf("reset%0d.busy", s), {31'd0, o_busy}, 32'd0);
         check($sformatf("reset%0d.done", s), {31'd0, o_done}, 32'd0);
         check($sformatf("reset%0d.result", s), {24'd0, o_result}, 32'd0);
         check($sformatf("reset%0d.cout", s), {31'd0, o_cout}, 32'd0);
         check($sformatf("reset%0d.ovf", s), {31'd0, o_ovf}, 32'd0);
      end
      @(negedge clk); rst = 1'b0;

      // one-bit full subtractor, exhaustive
      sel = 1;
      for (int v = 0; v < 8; v++) begin
         logic [2:0] abc;
         abc = 3'(v);
         run_op($sformatf("w1_sub_%0d", v), 1'b0, {7'd0, abc[2]}, {7'd0, abc[1]}, abc[0]);
      end

      // directed 8-bit, one bit per clock
      sel = 0;
      run_op("sub_05_03", 1'b0, 8'h05, 8'h03, 1'b0);
      run_op("sub_00_01", 1'b0, 8'h00, 8'h01, 1'b0);
      run_op("sub_80_01", 1'b0, 8'h80, 8'h01, 1'b0);
      run_op("add_ff_01", 1'b1, 8'hFF, 8'h01, 1'b0);
      run_op("add_7f_01", 1'b1, 8'h7F, 8'h01, 1'b0);
      run_op("add_10_20_c", 1'b1, 8'h10, 8'h20, 1'b1);

      // four bits per clock
      sel = 2;
      run_op("s4_sub_a5_5a", 1'b0, 8'hA5, 8'h5A, 1'b0);

      // randomized against the reference
      for (int s = 0; s < 3; s++) begin
         sel = s;
         for (int i = 0; i < 12; i++) begin
            run_op($sformatf("rand%0d_%0d", s, i), 1'($urandom), 8'($urandom),
                   8'($urandom), 1'($urandom));
         end
      end

      // start pulses mid-run are ignored; operands change mid-run
      sel = 0;
      model(8, 1'b0, 8'h9C, 8'h27, 1'b1, er, ec, eo);
      @(negedge clk);
      mode = 1'b0; a = 8'h9C; b = 8'h27; cin = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; a = 8'h11;
      dones = 0; done_edge = -1; first_res = 8'h00;
      for (int e = 1; e <= 20; e++) begin
         @(negedge clk);
         start = (e == 3 || e == 8);
         a = 8'($urandom); b = 8'($urandom); mode = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         if (o_done === 1'b1) begin
            dones++;
            if (done_edge < 0) begin
               done_edge = e;
               first_res = o_result;
            end
         end
      end
      check("hs.done_count", dones, 1);
      check("hs.done_edge", done_edge, 8);
      check("hs.result", {24'd0, first_res}, {24'd0, er});

      // asynchronous reset during RUN cycle 4
      @(negedge clk);
      mode = 1'b0; a = 8'h05; b = 8'h03; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst.busy", {31'd0, o_busy}, 32'd0);
      check("rst.done", {31'd0, o_done}, 32'd0);
      check("rst.result", {24'd0, o_result}, 32'd0);
      check("rst.cout", {31'd0, o_cout}, 32'd0);
      check("rst.ovf", {31'd0, o_ovf}, 32'd0);
      @(negedge clk); rst = 1'b0;
      dones = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (o_done === 1'b1 || o_busy === 1'b1) dones++;
      end
      check("rst.no_activity", dones, 0);
      run_op("post_rst_05_03", 1'b0, 8'h05, 8'h03, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Parametrised multi-cycle add/subtract unit built from a chained one-bit full add/sub cell, processing `STEP` bits per clock from LSB to MSB with a registered borrow/carry between chunks. It extends the team's one-bit full subtractor to `WIDTH`-bit operands, adds an add mode, signed-overflow detection and a start/busy/done handshake. It serves as the shared arithmetic engine for datapaths that trade latency for area.

## Interface
Parameters:
- `WIDTH`, 8: operand/result width in bits; ≥1.
- `STEP`, 1: bits processed per clock; must divide `WIDTH`. Elaboration error otherwise.

Ports:
- `clk`  in  1  sole clock; all state on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `mode`  in  1  0 = subtract (`a - b - cin`), 1 = add (`a + b + cin`).
- `a`  in  `WIDTH`  minuend/addend; captured with `start`.
- `b`  in  `WIDTH`  subtrahend/addend; captured with `start`.
- `cin`  in  1  borrow-in (sub) or carry-in (add); captured with `start`.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle completion pulse.
- `result`  out  `WIDTH`  final difference/sum; held until the next completion.
- `cout`  out  1  final borrow (sub) or carry (add).
- `ovf`  out  1  two's-complement signed overflow.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE to RUN on `start` = 1.
  - RUN to DONE after `N = WIDTH/STEP` RUN cycles.
  - DONE to IDLE unconditionally.
- In IDLE, `start` latches `a`, `b`, `mode` and `cin`. It also clears the chunk counter and loads the internal borrow/carry register with `cin`.
- Each RUN cycle:
  - Feed operand bits `[k*STEP +: STEP]` through `STEP` chained cells.
  - Write the chunk into the working shift register.
  - Register the last cell's borrow/carry.
  - Increment the counter.
- Subtract: `result = (a - b - cin) mod 2^WIDTH`. `cout = 1` iff `a < b + cin`, unsigned.
- Add: `result = (a + b + cin) mod 2^WIDTH`. `cout` is the carry out of the MSB.
- `ovf`:
  - sub: `a[MSB] != b[MSB]` and `result[MSB] != a[MSB]`.
  - add: `a[MSB] == b[MSB]` and `result[MSB] != a[MSB]`.
- `start` in RUN or DONE is ignored. It is not queued.
- Input changes after the capture edge have no effect on the operation in flight.
- `result`, `cout` and `ovf` are loaded only on the RUN to DONE edge. Intermediate values never appear on them.
- Reset, including mid-RUN: state IDLE; `busy`, `done`, `result`, `cout`, `ovf`, counter and internal registers all 0. The aborted operation produces no `done`.

## Timing
- `start` sampled high at edge 0: `busy` = 1 from edge 0.
- Chunks are processed at edges 1..N.
- At edge N: `busy` = 0, `done` = 1, and outputs are valid.
- At edge N+1: `done` = 0 and state is IDLE. The earliest next `start` is sampled at edge N+1.
- Latency from start to `done` is N cycles. Throughput is one operation per N+1 cycles.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Package `serial_addsub_pkg` holds:
  - state enum `addsub_state_t` (IDLE, RUN, DONE);
  - constants `MODE_SUB` = 0, `MODE_ADD` = 1.
- Sub-module `addsub_bit` is a one-bit cell: inputs `x`, `y`, `ci`, `mode`; outputs `s`, `co`.
  - Subtract: `s = x^y^ci`, `co = (~x&y) | (~(x^y)&ci)`.
  - Add: standard full adder.
  - It is instantiated `STEP` times in a generate chain.
- Top level holds the FSM, counter, operand shift registers and output registers.

## Test plan
- WIDTH=1, STEP=1, sub mode: exhaustive over the 8 combinations of `{a,b,cin}`. Each `{cout,result}` equals the one-bit full-subtractor truth table; `done` occurs 1 cycle after `start`.
- WIDTH=8, STEP=1, sub:
  - 0x05−0x03, cin0 gives 0x02, cout0, ovf0; `done` at edge 8, `busy` high for exactly 8 cycles.
  - 0x00−0x01 gives 0xFF, cout1.
  - 0x80−0x01 gives 0x7F, cout0, ovf1.
- WIDTH=8, STEP=1, add:
  - 0xFF+0x01 gives 0x00, cout1, ovf0.
  - 0x7F+0x01 gives 0x80, cout0, ovf1.
  - 0x10+0x20, cin1 gives 0x31.
- WIDTH=8, STEP=4, sub: 0xA5−0x5A gives 0x4B, cout0, ovf1; `done` at edge 2.
- Handshake:
  - Pulse `start` at edges 3 and 8 during an 8-cycle op, with different operands. Exactly one `done`, carrying the first operands' result.
  - Changing `a` mid-run does not alter the result.
- Reset: assert `rst` asynchronously at RUN cycle 4. All outputs 0 immediately, no `done`. After release, a new op 0x05−0x03 completes normally with 0x02.
